// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader
//
// Host-side driver for the FIR filter's bit-serial coefficient-load port and
// its sample-start handshake. Holds a bank of NCoeffs coefficients written by
// the host. On request it streams a snapshot of the bank to the filter,
// MSB first, starting with coeff[NCoeffs-1] and ending with coeff[0] bit 0.
// Start pulses and loads are kept mutually exclusive.
//
// Optional feature: define FIR_COEFF_LOADER_READBACK_EN to add a combinational
// bank readback port (rd_addr / rd_data). Core behaviour is identical either way.
//
// Ports:
//   clk            clock
//   rstN           synchronous, active-low reset
//   wr_en          bank write strobe
//   wr_addr        bank index; indices >= NCoeffs are ignored
//   wr_data        coefficient value
//   load_req       single-cycle request to stream the bank to the filter
//   start_req      single-cycle sample-start request
//   fir_done       filter done pulse, ends the active sample
//   coeff_load_out filter coeff_load_in, high while streaming
//   coeff_out      filter coeff_in, current stream bit
//   start_out      filter start, registered copy of an accepted start_req
//   busy           load pending or in progress
//   done           one-cycle pulse when a load completes
//   start_drop     one-cycle pulse when a start_req is rejected
//   rd_addr        (readback build) bank read index
//   rd_data        (readback build) bank read data, 0 for out-of-range index

module fir_coeff_loader #(
   parameter int unsigned DataWidth = 12,
   parameter int unsigned NTaps     = 9,
   localparam int unsigned NCoeffs   = (NTaps + 1) / 2,
   localparam int unsigned AddrWidth = $clog2(NCoeffs)
) (
   input  logic                 clk,
   input  logic                 rstN,
   input  logic                 wr_en,
   input  logic [AddrWidth-1:0] wr_addr,
   input  logic [DataWidth-1:0] wr_data,
   input  logic                 load_req,
   input  logic                 start_req,
   input  logic                 fir_done,
   output logic                 coeff_load_out,
   output logic                 coeff_out,
   output logic                 start_out,
   output logic                 busy,
   output logic                 done,
   output logic                 start_drop
`ifdef FIR_COEFF_LOADER_READBACK_EN
   ,
   input  logic [AddrWidth-1:0] rd_addr,
   output logic [DataWidth-1:0] rd_data
`endif
);

   localparam int unsigned TotalBits = NCoeffs * DataWidth;
   localparam int unsigned CntWidth  = $clog2(TotalBits);
   localparam logic [CntWidth-1:0]  LastBit  = CntWidth'(TotalBits - 1);
   localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NCoeffs - 1);

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StGap
   } state_e;

   // ---------------------------------------------------------------------------
   // Coefficient bank
   // ---------------------------------------------------------------------------
   logic [DataWidth-1:0] bank_q [NCoeffs];

   always_ff @(posedge clk) begin
      if (!rstN) begin
         for (int unsigned i = 0; i < NCoeffs; i++) begin
            bank_q[i] <= '0;
         end
      end else if (wr_en && (wr_addr <= LastAddr)) begin
         bank_q[wr_addr] <= wr_data;
      end
   end

   // Flattened bank with coeff[NCoeffs-1] in the top slice, so shifting the
   // vector left emits coeff[NCoeffs-1] MSB first and ends with coeff[0] bit 0.
   logic [TotalBits-1:0] snapshot;

   always_comb begin
      snapshot = '0;
      for (int unsigned i = 0; i < NCoeffs; i++) begin
         snapshot[i*DataWidth +: DataWidth] = bank_q[i];
      end
   end

`ifdef FIR_COEFF_LOADER_READBACK_EN
   // Reads the live bank, not the stream snapshot.
   always_comb begin
      rd_data = '0;
      if (rd_addr <= LastAddr) begin
         rd_data = bank_q[rd_addr];
      end
   end
`endif

   // ---------------------------------------------------------------------------
   // Load sequencer and start arbitration
   // ---------------------------------------------------------------------------
   state_e               state_q, state_d;
   logic                 load_pend_q, load_pend_d;
   logic                 fir_active_q, fir_active_d;
   logic [CntWidth-1:0]  cnt_q, cnt_d;
   logic [TotalBits-1:0] sreg_q, sreg_d;
   logic                 coeff_load_q, coeff_load_d;
   logic                 done_q, done_d;
   logic                 start_out_q, start_out_d;
   logic                 start_drop_q, start_drop_d;
   logic                 start_ok;

   always_ff @(posedge clk) begin
      if (!rstN) begin
         state_q      <= StIdle;
         load_pend_q  <= 1'b0;
         fir_active_q <= 1'b0;
         cnt_q        <= '0;
         sreg_q       <= '0;
         coeff_load_q <= 1'b0;
         done_q       <= 1'b0;
         start_out_q  <= 1'b0;
         start_drop_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         load_pend_q  <= load_pend_d;
         fir_active_q <= fir_active_d;
         cnt_q        <= cnt_d;
         sreg_q       <= sreg_d;
         coeff_load_q <= coeff_load_d;
         done_q       <= done_d;
         start_out_q  <= start_out_d;
         start_drop_q <= start_drop_d;
      end
   end

   assign busy = load_pend_q | (state_q != StIdle);

   always_comb begin
      state_d      = state_q;
      load_pend_d  = load_pend_q;
      cnt_d        = cnt_q;
      sreg_d       = sreg_q;
      coeff_load_d = coeff_load_q;
      done_d       = 1'b0;

      // A request while busy (pending, streaming or in the gap) is absorbed.
      if (load_req && !busy) begin
         load_pend_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            // Never start a load while the filter is processing a sample.
            if (load_pend_q && !fir_active_q) begin
               state_d      = StShift;
               load_pend_d  = 1'b0;
               cnt_d        = '0;
               sreg_d       = snapshot;
               coeff_load_d = 1'b1;
            end
         end
         StShift: begin
            sreg_d = sreg_q << 1;
            if (cnt_q == LastBit) begin
               state_d      = StGap;
               coeff_load_d = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StGap: begin
            // Lets the filter fall back from its load state before anything new.
            state_d = StIdle;
            done_d  = 1'b1;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // A start is only passed on from a quiet idle; a same-cycle load wins.
   assign start_ok     = start_req & (state_q == StIdle) & ~load_pend_q & ~load_req;
   assign start_out_d  = start_ok;
   assign start_drop_d = start_req & ~start_ok;

   // Set has priority over a coincident fir_done.
   always_comb begin
      fir_active_d = fir_active_q;
      if (start_out_q) begin
         fir_active_d = 1'b1;
      end else if (fir_done) begin
         fir_active_d = 1'b0;
      end
   end

   assign coeff_load_out = coeff_load_q;
   assign coeff_out      = sreg_q[TotalBits-1];
   assign start_out      = start_out_q;
   assign done           = done_q;
   assign start_drop     = start_drop_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Testbench for fir_coeff_loader: directed windows with a scoreboard for the
// serial stream, start/drop events and done pulses, plus a simple filter model
// that captures the streamed coefficients into slots.

module tb_fir_coeff_loader;

   localparam int DW   = 12;
   localparam int NC   = 5;
   localparam int AW   = 3;
   localparam int BITS = NC * DW;

   logic          clk;
   logic          rstN;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          load_req;
   logic          start_req;
   logic          fir_done;
   logic          coeff_load_out;
   logic          coeff_out;
   logic          start_out;
   logic          busy;
   logic          done;
   logic          start_drop;
`ifdef FIR_COEFF_LOADER_READBACK_EN
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
`endif

   int checks = 0;
   int errors = 0;

   bit exp_bits[$];
   bit exp_start[$];  // 1: start_out expected, 0: start_drop expected
   bit exp_done[$];

   logic [DW-1:0]   model_bank [NC];
   logic [BITS-1:0] fil_sr;
   logic [127:0]    obs_busy, obs_clo, obs_done, obs_start, obs_drop;

   fir_coeff_loader #(
      .DataWidth(DW),
      .NTaps    (9)
   ) dut (
      .clk           (clk),
      .rstN          (rstN),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .load_req      (load_req),
      .start_req     (start_req),
      .fir_done      (fir_done),
      .coeff_load_out(coeff_load_out),
      .coeff_out     (coeff_out),
      .start_out     (start_out),
      .busy          (busy),
      .done          (done),
      .start_drop    (start_drop)
`ifdef FIR_COEFF_LOADER_READBACK_EN
      ,
      .rd_addr       (rd_addr),
      .rd_data       (rd_data)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] span(input int lo, input int hi);
      logic [127:0] m;
      m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   // Filter model: shifts in coeff_out while coeff_load_out is high.
   always @(posedge clk) begin
      if (coeff_load_out) fil_sr <= {fil_sr[BITS-2:0], coeff_out};
   end

   // Monitor: pops expectations whenever the DUT presents an output event.
   always @(negedge clk) begin
      if (coeff_load_out) begin
         if (exp_bits.size() == 0) check("stream_extra_bit", 1, 0);
         else check("stream_bit", coeff_out, exp_bits.pop_front());
      end
      if (start_out || start_drop) begin
         if (exp_start.size() == 0) check("start_extra_event", {start_out, start_drop}, 0);
         else check("start_event", {start_out, start_drop},
                    exp_start.pop_front() ? 2'b10 : 2'b01);
      end
      if (done) begin
         if (exp_done.size() == 0) check("done_extra", 1, 0);
         else check("done_pulse", done, exp_done.pop_front());
      end
   end

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
   endtask

   task automatic push_stream();
      for (int i = NC - 1; i >= 0; i--) begin
         for (int b = DW - 1; b >= 0; b--) exp_bits.push_back(model_bank[i][b]);
      end
   endtask

   task automatic check_slots();
      for (int i = 0; i < NC; i++) begin
         check($sformatf("filter_slot%0d", i), fil_sr[i*DW +: DW], model_bank[i]);
      end
   endtask

   // Runs n cycles from posedge+1; k-indexed strobes, -1 disables a strobe.
   task automatic run_window(input int n, input int load_k, input int load2_k,
                             input int start_k, input int fdone_k, input int wr_k,
                             input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                             input int rst_k);
      obs_busy  = '0;
      obs_clo   = '0;
      obs_done  = '0;
      obs_start = '0;
      obs_drop  = '0;
      for (int k = 0; k < n; k++) begin
         load_req  = (k == load_k) || (k == load2_k);
         start_req = (k == start_k);
         fir_done  = (k == fdone_k);
         wr_en     = (k == wr_k);
         wr_addr   = wa;
         wr_data   = wd;
         rstN      = (k != rst_k);
         @(negedge clk);
         obs_busy[k]  = busy;
         obs_clo[k]   = coeff_load_out;
         obs_done[k]  = done;
         obs_start[k] = start_out;
         obs_drop[k]  = start_drop;
         @(posedge clk);
         #1;
      end
      load_req  = 1'b0;
      start_req = 1'b0;
      fir_done  = 1'b0;
      wr_en     = 1'b0;
      rstN      = 1'b1;
   endtask

   initial begin
      int idle_hits;
      rstN      = 1'b0;
      wr_en     = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;
      load_req  = 1'b0;
      start_req = 1'b0;
      fir_done  = 1'b0;
`ifdef FIR_COEFF_LOADER_READBACK_EN
      rd_addr   = '0;
`endif
      for (int i = 0; i < NC; i++) model_bank[i] = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", {coeff_load_out, coeff_out, start_out, busy, done, start_drop}, 0);
      @(posedge clk);
      #1;
      rstN = 1'b1;

      idle_hits = 0;
      repeat (100) begin
         @(negedge clk);
         if (coeff_load_out || coeff_out || start_out || busy || done || start_drop)
            idle_hits++;
      end
      check("idle_quiet_100", idle_hits, 0);
      @(posedge clk);
      #1;

      // Bank writes; out-of-range addresses must be ignored.
      wr(3'd0, 12'h7FF); model_bank[0] = 12'h7FF;
      wr(3'd1, 12'h001); model_bank[1] = 12'h001;
      wr(3'd2, 12'h800); model_bank[2] = 12'h800;
      wr(3'd3, 12'h123); model_bank[3] = 12'h123;
      wr(3'd4, 12'hFFF); model_bank[4] = 12'hFFF;
      wr(3'd5, 12'hABC);
      wr(3'd7, 12'h3C3);

      // Load 1: absorbed second load_req mid-stream, start_req dropped at stream cycle 30.
      push_stream();
      exp_done.push_back(1'b1);
      exp_start.push_back(1'b0);
      run_window(70, 0, 10, 32, -1, -1, '0, '0, -1);
      check("l1_busy", obs_busy, span(1, 62));
      check("l1_coeff_load", obs_clo, span(2, 61));
      check("l1_done", obs_done, span(63, 63));
      check("l1_start_out", obs_start, 0);
      check("l1_start_drop", obs_drop, span(33, 33));
      check_slots();

      // Load 2: write addr 2 during stream cycle 10; stream keeps old value.
      push_stream();
      exp_done.push_back(1'b1);
      run_window(70, 0, -1, -1, -1, 12, 3'd2, 12'h555, -1);
      check("l2_coeff_load", obs_clo, span(2, 61));
      check("l2_done", obs_done, span(63, 63));
      check_slots();
      model_bank[2] = 12'h555;

      // Load 3: same-cycle start_req and load_req in idle; load wins, new value streamed.
      push_stream();
      exp_done.push_back(1'b1);
      exp_start.push_back(1'b0);
      run_window(70, 0, -1, 0, -1, -1, '0, '0, -1);
      check("l3_start_drop", obs_drop, span(1, 1));
      check("l3_coeff_load", obs_clo, span(2, 61));
      check("l3_busy", obs_busy, span(1, 62));
      check_slots();

      // Sample in flight: load waits for fir_done, then shifts on the following edge.
      exp_start.push_back(1'b1);
      push_stream();
      exp_done.push_back(1'b1);
      run_window(110, 3, -1, 0, 43, -1, '0, '0, -1);
      check("fa_start_out", obs_start, span(1, 1));
      check("fa_busy", obs_busy, span(4, 105));
      check("fa_coeff_load", obs_clo, span(45, 104));
      check("fa_done", obs_done, span(106, 106));
      check_slots();

      // Reset at stream cycle 20 aborts the stream and clears the bank.
      push_stream();
      run_window(30, 0, -1, -1, -1, -1, '0, '0, 22);
      check("rst_busy", obs_busy, span(1, 22));
      check("rst_coeff_load", obs_clo, span(2, 22));
      check("rst_done", obs_done, 0);
      check("rst_bits_unsent", exp_bits.size(), 39);
      exp_bits.delete();
      for (int i = 0; i < NC; i++) model_bank[i] = '0;
`ifdef FIR_COEFF_LOADER_READBACK_EN
      for (int a = 0; a < 8; a++) begin
         rd_addr = 3'(a);
         #1;
         check($sformatf("readback_addr%0d", a), rd_data, 0);
      end
`endif

      // Load after reset streams the cleared bank.
      push_stream();
      exp_done.push_back(1'b1);
      run_window(70, 0, -1, -1, -1, -1, '0, '0, -1);
      check("l5_coeff_load", obs_clo, span(2, 61));
      check_slots();

      check("bits_outstanding", exp_bits.size(), 0);
      check("starts_outstanding", exp_start.size(), 0);
      check("dones_outstanding", exp_done.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fir_coeff_loader.md
Name: fir_coeff_loader

Overview:
- Host-side driver for the FIR filter's bit-serial coefficient-load interface and its sample-start handshake.
- Holds a parallel bank of NCoeffs signed coefficients, written by the host.
- On request, streams the coefficients bit-serially on coeff_load_out/coeff_out.
- Arbitrates start pulses so a sample never starts during a load, and a load never starts during a sample.

Parameters:
- DataWidth, 12, coefficient width; SFix<1,DataWidth-1>, must match the filter.
- NTaps, 9, filter tap count; must be odd.
- NCoeffs, (NTaps+1)/2, derived; number of stored coefficients.

Ports:
- clk  in  1  clock.
- rstN  in  1  reset; synchronous, active-low.
- wr_en  in  1  bank write strobe.
- wr_addr  in  $clog2(NCoeffs)  bank index.
- wr_data  in  DataWidth  coefficient value.
- load_req  in  1  single-cycle request to stream the bank to the filter.
- start_req  in  1  single-cycle sample-start request from the sample source.
- fir_done  in  1  filter done pulse.
- coeff_load_out  out  1  to filter coeff_load_in.
- coeff_out  out  1  to filter coeff_in.
- start_out  out  1  to filter start.
- busy  out  1  load pending or in progress.
- done  out  1  one-cycle pulse when a load completes.
- start_drop  out  1  one-cycle pulse when a start_req is rejected.

Behaviour:
- Reset:
  - bank entries = 0, shift register = 0, bit counter = 0, state IDLE, fir_active = 0, load_pend = 0.
  - All outputs 0. Reset mid-stream aborts immediately; coeff_load_out = 0 on the next cycle.
- Bank writes:
  - Accepted every cycle, including during streaming. A write takes effect on the clock edge.
  - wr_addr >= NCoeffs is ignored.
  - Streaming uses a snapshot captured at stream start, so mid-stream writes affect only the next load.
- fir_active flag:
  - Set when start_out = 1; cleared on fir_done.
  - If both occur in the same cycle, set wins.
- Load request handling:
  - load_req sets load_pend.
  - load_req while already busy (pending or streaming) is absorbed and does not queue a second load.
- States:
  - IDLE: if load_pend and !fir_active -> SHIFT; capture snapshot and clear load_pend.
  - SHIFT: for NCoeffs*DataWidth cycles:
    - coeff_load_out = 1 (registered).
    - coeff_out = current stream bit.
    - After the last bit -> GAP.
  - GAP: one cycle with coeff_load_out = 0 and busy = 1, so the filter can return from its load state to idle. Then -> IDLE, with done = 1 in the first IDLE cycle.
- Bit order:
  - Coeff[NCoeffs-1] is sent first, MSB first, down to bit 0.
  - Then coeff[NCoeffs-2], and so on, ending with coeff[0] bit 0.
  - After NCoeffs*DataWidth shifts the filter holds coeff[i] in slot i.
- busy:
  - Combinational: load_pend | state != IDLE.
  - Rises the cycle after load_req. Falls in the same cycle done pulses.
- Start handling:
  - start_out is a registered copy of start_req, issued only when state == IDLE, !load_pend and !load_req.
  - Otherwise start_drop pulses instead; there is no queuing.
  - Latency start_req -> start_out: 1 cycle.
- Simultaneous events:
  - start_req and load_req in the same IDLE cycle: the start is dropped and the load wins.
  - load_req while fir_active: the load waits in IDLE until fir_done clears fir_active, then enters SHIFT on the following edge.
- Counters:
  - The bit counter is sized $clog2(NCoeffs*DataWidth).
  - It resets to 0 on SHIFT entry and does not wrap during a stream.

Optional Feature:
- Macro: FIR_COEFF_LOADER_READBACK_EN.
- When defined: adds inputs rd_addr ($clog2(NCoeffs)) and output rd_data (DataWidth).
  - rd_data is a combinational read of the bank, not the snapshot.
  - rd_addr >= NCoeffs returns 0.
- When undefined: these ports and their logic are absent. Core behaviour is identical either way.

Test Plan:
- Reset, then hold idle -> all outputs 0 and no coeff_load_out activity for 100 cycles.
- Write coeffs {0x7FF,0x001,0x800,0x123,0xFFF} at addr 0..4, then pulse load_req:
  - busy is high from cycle +1.
  - coeff_load_out is high for exactly 60 cycles starting at cycle +2.
  - The serial stream equals 0xFFF,0x123,0x800,0x001,0x7FF, MSB first.
  - A GAP cycle follows, then a done pulse.
  - A connected filter model holds coeff[i] in slot i.
- Pulse start_req at stream cycle 30 -> start_drop = 1 the next cycle; start_out stays 0; the stream is unaffected.
- Pulse start_req (start_out at +1), then load_req 3 cycles later with fir_done 40 cycles later:
  - SHIFT is entered the edge after fir_done.
  - No coeff_load_out while fir_active.
- Write addr 2 = 0x555 during stream cycle 10 -> the current stream still sends the old value; the next load sends 0x555.
- Deassert rstN at stream cycle 20 -> the next cycle coeff_load_out = busy = 0 and the bank reads 0 (readback build).
